// File: rtl/mod6_pkg.sv
// Shared types and constants for the mod-6 sequence checker and its helpers.
package mod6_pkg;

    typedef enum logic [1:0] {
        ACQ   = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } mod6_state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_SEQ     = 2'b10;

    localparam logic [2:0] MOD6_LAST = 3'd5;

    function automatic logic is_illegal(input logic [2:0] v);
        return (v > MOD6_LAST);
    endfunction

endpackage

// File: rtl/mod6_next.sv
// Next-expected-value function of a mod-6 counter: hold when not advancing,
// otherwise increment with 5 -> 0 wrap.
module mod6_next
    import mod6_pkg::*;
(
    input  logic [2:0] prev_i,
    input  logic       adv_i,
    output logic [2:0] expected_o,
    output logic       is_wrap_o
);

    always_comb begin
        is_wrap_o  = adv_i && (prev_i == MOD6_LAST);
        expected_o = prev_i;
        if (adv_i) begin
            if (prev_i == MOD6_LAST) begin
                expected_o = 3'd0;
            end else begin
                expected_o = prev_i + 3'd1;
            end
        end
    end

endmodule

// File: rtl/mod6_count_checker.sv
// Monitors a mod-6 counter: locks onto its sequence, ticks and counts wraps, flags faults.
// Define MOD6_CHK_STICKY_ERR_EN to hold faults until reset; otherwise a fault re-acquires.
module mod6_count_checker
    import mod6_pkg::*;
#(
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        q_in,
    input  logic              adv,
    output logic              wrap_tick,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              locked,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [1:0]        dbg_state
);

    // Handshake: none. q_in/adv are sampled on every rising clk edge; all
    // outputs are registered and reflect that sample one edge later.

    mod6_state_e       state_q, state_d;
    logic [2:0]        prev_q, prev_d;
    logic              wrap_tick_q, wrap_tick_d;
    logic [WRAP_W-1:0] wrap_count_q, wrap_count_d;
    logic              locked_q, locked_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;

    logic [2:0]        expected;
    logic              is_wrap;

    mod6_next u_next (
        .prev_i     (prev_q),
        .adv_i      (adv),
        .expected_o (expected),
        .is_wrap_o  (is_wrap)
    );

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        wrap_tick_d  = 1'b0;
        wrap_count_d = wrap_count_q;
        locked_d     = 1'b0;
        err_d        = 1'b0;
        err_code_d   = err_code_q;
        case (state_q)
            ACQ: begin
                // Capture never counts as a wrap, even when the captured value is 0.
                if (is_illegal(q_in)) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_ILLEGAL;
                end else begin
                    prev_d  = q_in;
                    state_d = TRACK;
                end
            end
            TRACK: begin
                if (q_in == expected) begin
                    prev_d   = q_in;
                    locked_d = 1'b1;
                    if (is_wrap) begin
                        wrap_tick_d  = 1'b1;
                        wrap_count_d = wrap_count_q + {{(WRAP_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    err_d      = 1'b1;
                    err_code_d = is_illegal(q_in) ? ERR_ILLEGAL : ERR_SEQ;
`ifdef MOD6_CHK_STICKY_ERR_EN
                    state_d    = FAULT;
`else
                    state_d    = ACQ;
`endif
                end
            end
            FAULT: begin
                err_d = 1'b1;
            end
            default: begin
                state_d = ACQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ACQ;
            prev_q       <= 3'd0;
            wrap_tick_q  <= 1'b0;
            wrap_count_q <= '0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            wrap_tick_q  <= wrap_tick_d;
            wrap_count_q <= wrap_count_d;
            locked_q     <= locked_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
        end
    end

    assign wrap_tick  = wrap_tick_q;
    assign wrap_count = wrap_count_q;
    assign locked     = locked_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_mod6_count_checker.sv
// Scoreboard bench for mod6_count_checker: directed scenarios plus randomized counter traffic.
module tb_mod6_count_checker;
    import mod6_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] q_in = 3'd0;
    logic       adv = 1'b1;

    logic       wrap_tick, locked, err;
    logic [7:0] wrap_count;
    logic [1:0] err_code, dbg_state;
    logic       wrap_tick2, locked2, err2;
    logic [1:0] wrap_count2, err_code2, dbg_state2;

    mod6_count_checker #(.WRAP_W(8)) dut (
        .clk(clk), .reset(reset), .q_in(q_in), .adv(adv),
        .wrap_tick(wrap_tick), .wrap_count(wrap_count), .locked(locked),
        .err(err), .err_code(err_code), .dbg_state(dbg_state)
    );

    mod6_count_checker #(.WRAP_W(2)) dut2 (
        .clk(clk), .reset(reset), .q_in(q_in), .adv(adv),
        .wrap_tick(wrap_tick2), .wrap_count(wrap_count2), .locked(locked2),
        .err(err2), .err_code(err_code2), .dbg_state(dbg_state2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       tick;
        logic [7:0] wc;
        logic [1:0] wc2;
        logic       locked;
        logic       err;
        logic [1:0] code;
        logic [1:0] st;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: "is the checker following the counter, and since when".
    bit         m_trk = 1'b0;
    bit         m_flt = 1'b0;
    int         m_prev = 0;
    int         m_wraps = 0;
    logic [1:0] m_code = 2'b00;
    int         cnt = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [2:0] q, input logic a);
        exp_t e;
        int   want;
        @(negedge clk);
        reset = r;
        q_in  = q;
        adv   = a;
        e = '0;
        if (r) begin
            m_trk = 0; m_flt = 0; m_prev = 0; m_wraps = 0; m_code = 2'b00;
        end else if (m_flt) begin
            e.err = 1'b1;
        end else if (!m_trk) begin
            if (int'(q) <= 5) begin
                m_prev = int'(q);
                m_trk  = 1;
            end else begin
                m_code = 2'b01;
                e.err  = 1'b1;
            end
        end else begin
            want = a ? (m_prev + 1) % 6 : m_prev;
            if (int'(q) == want) begin
                e.locked = 1'b1;
                if (a && m_prev == 5) begin
                    e.tick = 1'b1;
                    m_wraps++;
                end
                m_prev = int'(q);
            end else begin
                m_code = (int'(q) > 5) ? 2'b01 : 2'b10;
                e.err  = 1'b1;
`ifdef MOD6_CHK_STICKY_ERR_EN
                m_flt = 1;
`else
                m_trk = 0;
`endif
            end
        end
        e.wc   = 8'(m_wraps % 256);
        e.wc2  = 2'(m_wraps % 4);
        e.code = m_code;
        e.st   = m_flt ? 2'd2 : (m_trk ? 2'd1 : 2'd0);
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 3'd0, 1'b1);
        cnt = 0;
    endtask

    // Free-running counter: present cnt, then advance.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 3'(cnt), 1'b1);
            cnt = (cnt + 1) % 6;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("wrap_tick",   wrap_tick,   mon_e.tick);
                chk("wrap_count",  wrap_count,  mon_e.wc);
                chk("locked",      locked,      mon_e.locked);
                chk("err",         err,         mon_e.err);
                chk("err_code",    err_code,    mon_e.code);
                chk("state",       dbg_state,   mon_e.st);
                chk("wrap_count2", wrap_count2, mon_e.wc2);
                chk("wrap_tick2",  wrap_tick2,  mon_e.tick);
                chk("err2",        err2,        mon_e.err);
            end
        end
    end

    initial begin
        int drain;
        logic a;
        logic [2:0] q;

        do_reset(2);
        run(20);

        run(2);
        drive(1'b0, 3'd7, 1'b1);
        cnt = (cnt + 1) % 6;
        run(10);

        do_reset(2);
        run(3);
        drive(1'b0, 3'd4, 1'b1);
        cnt = 5;
        run(8);

        do_reset(2);
        run(6);
        repeat (3) drive(1'b0, 3'd5, 1'b0);
        drive(1'b0, 3'd0, 1'b1);
        cnt = 1;
        run(4);

        do_reset(2);
        run(32);

        // Reset lands on the 5 -> 0 edge.
        while (cnt != 5) run(1);
        run(1);
        drive(1'b1, 3'd0, 1'b1);
        cnt = 0;
        run(3);

        do_reset(2);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                drive(1'b1, 3'd0, 1'b1);
                cnt = 0;
            end else begin
                a = ($urandom_range(0, 3) != 0);
                if (a) cnt = (cnt + 1) % 6;
                q = 3'(cnt);
                if ($urandom_range(0, 15) == 0) q = 3'($urandom_range(0, 7));
                drive(1'b0, q, a);
            end
        end

        drain = 0;
        while (exp_q.size() > 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        #3;
        chk("drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mod6_count_checker.md
# mod6_count_checker

Downstream monitor for the free-running mod-6 counter. It samples the 3-bit count every clock, locks onto the sequence 0→1→2→3→4→5→0, and emits a one-cycle tick on each 5→0 wrap. It also keeps a wrap counter for the next cascade stage, such as a minutes/hours divider, and flags illegal codes (6, 7) or skipped or repeated states. It sits directly on the counter's `q` output and shares its clock and reset.

## Interface
- `WRAP_W`, default 8: width of the wrap event counter.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `q_in`  in  3  count value from the mod-6 counter.
- `adv`  in  1  counter advances this cycle. Tie to 1 for the free-running counter; 0 means the count must hold.
- `wrap_tick`  out  1  one-cycle pulse; the accepted sample was a 5→0 transition.
- `wrap_count`  out  WRAP_W  number of wraps since reset, modulo 2^WRAP_W.
- `locked`  out  1  checker is tracking a valid sequence.
- `err`  out  1  sequence fault indication.
- `err_code`  out  2  last fault: 00 none, 01 illegal code (q_in > 5), 10 sequence break (legal code, wrong value).

## Operation
- States: ACQ, TRACK, FAULT. Internal register `prev` (3 bits).
- ACQ:
  - q_in ≤ 5: prev ← q_in, go to TRACK.
  - q_in > 5: err_code ← 01, err asserted one cycle, stay in ACQ.
- TRACK: expected value = adv ? (prev == 5 ? 0 : prev + 1) : prev.
  - q_in == expected: prev ← q_in.
  - If adv = 1 and prev = 5 (so q_in = 0): wrap_tick = 1 and wrap_count increments, wrapping from all-ones to 0.
  - q_in != expected: err_code ← (q_in > 5 ? 01 : 10), err ← 1, go to FAULT (sticky build) or ACQ (non-sticky build).
- FAULT: locked = 0 and err = 1 until reset. q_in is ignored and wrap_count is frozen.
- No wrap is counted on the ACQ→TRACK capture, even if the captured value is 0.
- Arithmetic uses only 3-bit compares and an increment. Values 6 and 7 are never generated internally.
- Reset mid-operation: all state returns to reset values on the next edge. Any pending tick is dropped and wrap_count is cleared.

## Timing
- All outputs are registered and update on the rising clk edge after the q_in sample (latency 1).
- Reset values: state ACQ, prev 0, wrap_tick 0, wrap_count 0, locked 0, err 0, err_code 00.
- locked rises one cycle after the ACQ capture edge. It falls on the same edge that raises err.
- With the counter released from reset together with the checker:
  - first post-reset sample is q_in = 0, captured in ACQ;
  - locked = 1 from the next edge;
  - first wrap_tick occurs 6 cycles after capture, then every 6 cycles.
- wrap_tick and err are never high in the same cycle.
- An adv = 0 cycle with an unchanged q_in is legal and produces no tick.

## Configuration
- `MOD6_CHK_STICKY_ERR_EN` defined:
  - a TRACK mismatch enters FAULT;
  - err stays high and locked stays low until reset.
- Not defined:
  - a mismatch pulses err for one cycle and returns to ACQ;
  - the faulting sample is not captured; ACQ evaluates the next sample, and locked returns one cycle after capture;
  - err_code holds the last fault code until reset.

## Structure
- Shared package `mod6_pkg`:
  - state enum (ACQ/TRACK/FAULT);
  - err_code constants (ERR_NONE, ERR_ILLEGAL, ERR_SEQ);
  - constant MOD6_LAST = 3'd5.
- One natural sub-module, `mod6_next`: combinational next-expected-value function (prev, adv → expected, is_wrap). It is reusable by the upstream counter's own checks.
- The wrap counter is inline. No other hierarchy.

## Test plan
- Reset held 2 cycles, then free-running counter with adv = 1 for 20 cycles:
  - locked = 1 at cycle 2 after release;
  - wrap_tick pulses at 6-cycle spacing;
  - wrap_count = 3 at the end.
- Force q_in = 7 mid-TRACK:
  - err = 1, err_code = 01, locked = 0 next cycle;
  - sticky build: err stays 1 for 10 more cycles;
  - non-sticky build: err is a one-cycle pulse and locked returns after ACQ recapture.
- Force 2→4 skip: err_code = 10, wrap_count frozen, no wrap_tick.
- adv = 0 for 3 cycles at q_in = 5, then adv = 1 and q_in = 0: no error, exactly one wrap_tick, wrap_count increments by 1.
- WRAP_W = 2, run 5 wraps: wrap_count sequence is 1, 2, 3, 0, 1.
- Assert reset on the same cycle as a 5→0 transition: wrap_tick = 0, wrap_count = 0, state ACQ next cycle.
